// File: rtl/core_v_mcu_pkg.sv
// SoC-wide types and constants shared by the debug system-bus access path.
package core_v_mcu_pkg;

    localparam int unsigned SBA_ADDR_W = 64;
    localparam int unsigned SBA_DATA_W = 64;
    localparam int unsigned SBA_STRB_W = SBA_DATA_W / 8;

    typedef logic [SBA_ADDR_W-1:0] sba_addr_t;
    typedef logic [SBA_DATA_W-1:0] sba_data_t;
    typedef logic [SBA_STRB_W-1:0] sba_strb_t;

    // A zero-sized window leaves every address reachable.
    localparam sba_addr_t DEBUG_SBA_WIN_BASE = '0;
    localparam sba_addr_t DEBUG_SBA_WIN_SIZE = '0;

endpackage

// File: rtl/dbg_sba_guard.sv
// Guards debug-module SBA accesses towards the mem-to-AXI bridge: address window
// filtering, per-transaction timeout with draining of late bridge traffic.
module dbg_sba_guard
    import core_v_mcu_pkg::*;
#(
    parameter int unsigned          AddrWidth     = 64,
    parameter int unsigned          DataWidth     = 64,
    parameter int unsigned          TimeoutCycles = 1024,
    parameter logic [AddrWidth-1:0] WinBase       = AddrWidth'(DEBUG_SBA_WIN_BASE),
    parameter logic [AddrWidth-1:0] WinSize       = AddrWidth'(DEBUG_SBA_WIN_SIZE)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   slv_req_i,
    input  logic [AddrWidth-1:0]   slv_addr_i,
    input  logic                   slv_we_i,
    input  logic [DataWidth-1:0]   slv_wdata_i,
    input  logic [DataWidth/8-1:0] slv_be_i,
    output logic                   slv_gnt_o,
    output logic                   slv_rvalid_o,
    output logic [DataWidth-1:0]   slv_rdata_o,
    output logic                   slv_err_o,
    output logic                   mst_req_o,
    output logic [AddrWidth-1:0]   mst_addr_o,
    output logic                   mst_we_o,
    output logic [DataWidth-1:0]   mst_wdata_o,
    output logic [DataWidth/8-1:0] mst_be_o,
    input  logic                   mst_gnt_i,
    input  logic                   mst_rvalid_i,
    input  logic [DataWidth-1:0]   mst_rdata_i,
    input  logic                   mst_err_i,
    output logic                   timeout_o,
    output logic                   busy_o,
    output logic [7:0]             err_cnt_o
);

    localparam int unsigned TmrW = $clog2(TimeoutCycles + 1);
    // The timeout is registered, so it is decided one count early to land on count TimeoutCycles-1.
    localparam logic [TmrW-1:0] TmrLast = TmrW'(TimeoutCycles - 2);

    typedef enum logic [2:0] {IDLE, REQ, RSP, ERR, DRAIN_REQ, DRAIN_RSP} state_e;

    state_e          state;
    logic [TmrW-1:0] timer;
    logic            win_hit;
    logic            tmo_hit;
    logic            cnt_inc;

    function automatic logic in_window(input logic [AddrWidth-1:0] addr);
        if (WinSize == '0) return 1'b1;
        return (addr >= WinBase) && ((addr - WinBase) < WinSize);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] val);
        return (val == 8'hFF) ? val : val + 8'd1;
    endfunction

    assign win_hit   = in_window(slv_addr_i);
    assign slv_gnt_o = (state == IDLE) && slv_req_i;
    assign busy_o    = (state != IDLE);
    // A response arriving on the deadline cycle completes normally instead of timing out.
    assign tmo_hit   = ((state == REQ) || (state == RSP)) && (timer == TmrLast)
                       && !((state == RSP) && mst_rvalid_i);
    assign cnt_inc   = ((state == IDLE) && slv_req_i && !win_hit) || tmo_hit
                       || ((state == RSP) && mst_rvalid_i && mst_err_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            timer        <= '0;
            mst_req_o    <= 1'b0;
            mst_addr_o   <= '0;
            mst_we_o     <= 1'b0;
            mst_wdata_o  <= '0;
            mst_be_o     <= '0;
            slv_rvalid_o <= 1'b0;
            slv_rdata_o  <= '0;
            slv_err_o    <= 1'b0;
            timeout_o    <= 1'b0;
            err_cnt_o    <= '0;
        end else begin
            slv_rvalid_o <= 1'b0;
            timeout_o    <= 1'b0;
            if (clear_i) begin
                err_cnt_o <= '0;
            end else if (cnt_inc) begin
                err_cnt_o <= sat_inc(err_cnt_o);
            end
            if ((state == REQ) || (state == RSP)) begin
                timer <= timer + TmrW'(1);
            end
            if (tmo_hit) begin
                timeout_o    <= 1'b1;
                slv_rvalid_o <= 1'b1;
                slv_err_o    <= 1'b1;
                slv_rdata_o  <= '0;
            end
            unique case (state)
                IDLE: begin
                    if (slv_req_i) begin
                        if (win_hit) begin
                            mst_req_o   <= 1'b1;
                            mst_addr_o  <= slv_addr_i;
                            mst_we_o    <= slv_we_i;
                            mst_wdata_o <= slv_wdata_i;
                            mst_be_o    <= slv_be_i;
                            timer       <= '0;
                            state       <= REQ;
                        end else begin
                            state <= ERR;
                        end
                    end
                end
                ERR: begin
                    slv_rvalid_o <= 1'b1;
                    slv_err_o    <= 1'b1;
                    slv_rdata_o  <= '0;
                    state        <= IDLE;
                end
                REQ: begin
                    if (mst_gnt_i) begin
                        mst_req_o <= 1'b0;
                        state     <= tmo_hit ? DRAIN_RSP : RSP;
                    end else if (tmo_hit) begin
                        state <= DRAIN_REQ;
                    end
                end
                RSP: begin
                    if (mst_rvalid_i) begin
                        slv_rvalid_o <= 1'b1;
                        slv_rdata_o  <= mst_rdata_i;
                        slv_err_o    <= mst_err_i;
                        state        <= IDLE;
                    end else if (tmo_hit) begin
                        state <= DRAIN_RSP;
                    end
                end
                DRAIN_REQ: begin
                    if (mst_gnt_i) begin
                        mst_req_o <= 1'b0;
                        state     <= DRAIN_RSP;
                    end
                end
                DRAIN_RSP: begin
                    if (mst_rvalid_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dbg_sba_guard.md
DBG_SBA_GUARD -- requirements
Module: dbg_sba_guard

Interface
REQ-001 SHALL have parameter AddrWidth, default 64, address width of both ports.
REQ-002 SHALL have parameter DataWidth, default 64, data width of both ports; strobe width is DataWidth/8.
REQ-003 SHALL have parameter TimeoutCycles, default 1024, cycles allowed per transaction; legal values are 2 or more.
REQ-004 SHALL have parameters WinBase (default 0) and WinSize (default 0), the allowed SBA address window; WinSize 0 disables the window check.
REQ-005 SHALL have port clk_i, input, 1 bit, clock.
REQ-006 SHALL have port rst_ni, input, 1 bit, reset: asynchronous, active-low.
REQ-007 SHALL have port clear_i, input, 1 bit, synchronous clear of err_cnt_o.
REQ-008 SHALL have port slv_req_i, input, 1 bit, SBA request from the debug module, held until granted.
REQ-009 SHALL have ports slv_addr_i (AddrWidth), slv_we_i (1), slv_wdata_i (DataWidth) and slv_be_i (DataWidth/8), all inputs, carrying the SBA request fields.
REQ-010 SHALL have port slv_gnt_o, output, 1 bit, request grant.
REQ-011 SHALL have ports slv_rvalid_o (1), slv_rdata_o (DataWidth) and slv_err_o (1), all outputs, carrying the response to the debug module.
REQ-012 SHALL have ports mst_req_o (1), mst_addr_o (AddrWidth), mst_we_o (1), mst_wdata_o (DataWidth) and mst_be_o (DataWidth/8), all outputs, carrying the request to the mem-to-AXI bridge.
REQ-013 SHALL have ports mst_gnt_i (1), mst_rvalid_i (1), mst_rdata_i (DataWidth) and mst_err_i (1), all inputs, carrying the bridge grant and response.
REQ-014 SHALL have port timeout_o, output, 1 bit, single-cycle pulse on each transaction timeout.
REQ-015 SHALL have port busy_o, output, 1 bit, high when the FSM is not in IDLE.
REQ-016 SHALL have port err_cnt_o, output, 8 bits, saturating error count.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, RSP, ERR, DRAIN_REQ and DRAIN_RSP, with one transaction in flight at most.
REQ-018 In IDLE, slv_gnt_o SHALL equal slv_req_i combinationally; in every other state it SHALL be 0.
REQ-019 On accept, in-window requests SHALL latch all request fields, clear the timer and go to REQ; out-of-window requests SHALL go to ERR.
REQ-020 Window hit SHALL be the unsigned compare addr >= WinBase and (addr - WinBase) < WinSize, evaluated at full AddrWidth.
REQ-021 In REQ, mst_req_o SHALL be 1 with the latched fields; on mst_gnt_i the FSM SHALL go to RSP.
REQ-022 In RSP, on mst_rvalid_i the FSM SHALL register rdata/err to the slave port, pulse slv_rvalid_o the next cycle, and return to IDLE.
REQ-023 ERR SHALL last one cycle, then IDLE; slv_rvalid_o=1, slv_err_o=1 and slv_rdata_o=0 SHALL appear the cycle after ERR is entered; no mst_req_o is issued.
REQ-024 The timer SHALL increment every cycle in REQ and RSP; at count TimeoutCycles-1 without completion it SHALL trigger: error response (as REQ-023), timeout_o pulse, REQ->DRAIN_REQ, RSP->DRAIN_RSP.
REQ-025 DRAIN_REQ SHALL hold mst_req_o with unchanged fields until mst_gnt_i, then go to DRAIN_RSP.
REQ-026 DRAIN_RSP SHALL discard mst_rvalid_i (no slv_rvalid_o) and then return to IDLE.
REQ-027 If mst_rvalid_i arrives in RSP in the same cycle as the timeout, the completion SHALL win and no timeout is flagged.
REQ-028 err_cnt_o SHALL increment on timeout, out-of-window access and mst_err_i responses, saturate at 255, and clear on clear_i, with clear winning over a simultaneous increment.
REQ-029 slv_rvalid_o SHALL be exactly one cycle wide per accepted request.

Reset
REQ-030 Asserting rst_ni SHALL immediately force IDLE, all outputs 0 (except slv_gnt_o per REQ-018), timer 0 and err_cnt_o 0, including mid-transaction; late bridge responses after reset SHALL be ignored in IDLE.

Structure
REQ-031 Address, data and strobe types and the SBA window constants (DEBUG_SBA_WIN_BASE, DEBUG_SBA_WIN_SIZE) SHALL live in core_v_mcu_pkg; the FSM state enum SHALL stay local to the module.
REQ-032 The block SHALL be a single module with no sub-module; the timer width SHALL be $clog2(TimeoutCycles+1).

Verification
REQ-033 In-window read at 0x8000_0000, grant after 2 cycles, rvalid with rdata 0xDEAD_BEEF after 3 more -> slv_rvalid_o one cycle later with 0xDEAD_BEEF, err 0.
REQ-034 WinBase=0x8000_0000, WinSize=0x1000, write to 0x8000_1000 -> no mst_req_o; slv_err_o=1 two cycles after gnt; err_cnt_o=1.
REQ-035 TimeoutCycles=8, bridge never responds -> timeout_o and error response 8 cycles after accept; busy_o stays 1 until a late rvalid is discarded.
REQ-036 TimeoutCycles=8, mst_gnt_i withheld for 20 cycles -> timeout at cycle 8; mst_req_o held until gnt; next request is not granted until the drain completes.
REQ-037 300 forced errors, then clear_i asserted together with an error -> err_cnt_o saturates at 255, then reads 0.
